fp_add_sequencer: RTL and testbench

- Sequences one IEEE-754 single-precision addition through the shared mantissa_alignment_and_adder datapath.
- Accepts packed operands on a valid/ready handshake and unpacks them.
- Handles special values without using the datapath.
- Drives the datapath's per-operation Reset/Load protocol and waits for Result_stable.
- Normalizes the raw sum iteratively, then packs the result and presents it on an output handshake.

---
 rtl/fp_add_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// Sequences one single-precision addition through the shared mantissa alignment/adder datapath.
// Optional WAIT timeout is compiled in with FPADD_TIMEOUT_EN.
module fp_add_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Timeout,
  output logic        Dp_Reset,
  output logic        Dp_Load,
  output logic        Dp_S_A,
  output logic        Dp_S_B,
  output logic [7:0]  Dp_E_A,
  output logic [7:0]  Dp_E_B,
  output logic [23:0] Dp_M_A,
  output logic [23:0] Dp_M_B,
  input  logic        Dp_S_Result,
  input  logic [7:0]  Dp_E_Result,
  input  logic [23:0] Dp_M_Result,
  input  logic        Dp_Carry,
  input  logic        Dp_Result_stable
);

  typedef enum logic [2:0] {
    StIdle, StCheck, StClr, StLoad, StWait, StNorm, StPack, StDone
  } state_e;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        s_q, s_d;
  logic [7:0]  e_q, e_d;
  logic [23:0] m_q, m_d;
  logic        carry_q, carry_d;
  logic        first_q, first_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
`ifdef FPADD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
`endif

  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [8:0] e_inc;

  // Exponent 0 counts as zero, so denormals are flushed.
  assign a_zero = (a_q[30:23] == 8'h00);
  assign b_zero = (b_q[30:23] == 8'h00);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
  assign e_inc  = {1'b0, e_q} + 9'd1;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    carry_d  = carry_q;
    first_d  = first_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`ifdef FPADD_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (In_valid) begin
          a_d      = A;
          b_d      = B;
          result_d = 32'h0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
`ifdef FPADD_TIMEOUT_EN
          to_d     = 1'b0;
`endif
          state_d  = StCheck;
        end
      end
      StCheck: begin
        state_d = StDone;
        if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]))) begin
          result_d = QNaN;
        end else if (a_inf) begin
          result_d = a_q;
        end else if (b_inf) begin
          result_d = b_q;
        end else if (a_zero && b_zero) begin
          result_d = {a_q[31] & b_q[31], 31'h0};
        end else if (a_zero) begin
          result_d = b_q;
        end else if (b_zero) begin
          result_d = a_q;
        end else begin
          state_d = StClr;
        end
      end
      StClr: begin
        state_d = StLoad;
      end
      StLoad: begin
`ifdef FPADD_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (Dp_Result_stable) begin
          s_d     = Dp_S_Result;
          e_d     = Dp_E_Result;
          m_d     = Dp_M_Result;
          carry_d = Dp_Carry;
          first_d = 1'b1;
          state_d = StNorm;
`ifdef FPADD_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = QNaN;
          to_d     = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StNorm: begin
        first_d = 1'b0;
        if (first_q && carry_q) begin
          m_d = {1'b1, m_q[23:1]};
          e_d = e_inc[7:0];
          if (e_inc >= 9'd255) begin
            ovf_d   = 1'b1;
            e_d     = 8'hFF;
            m_d     = 24'h0;
            state_d = StPack;
          end
        end else if (m_q == 24'h0) begin
          s_d     = 1'b0;
          e_d     = 8'h00;
          state_d = StPack;
        end else if (!m_q[23]) begin
          if (e_q > 8'd1) begin
            m_d = {m_q[22:0], 1'b0};
            e_d = e_q - 8'd1;
          end else begin
            unf_d   = 1'b1;
            e_d     = 8'h00;
            m_d     = 24'h0;
            state_d = StPack;
          end
        end else begin
          state_d = StPack;
        end
      end
      StPack: begin
        result_d = {s_q, e_q, m_q[22:0]};
        state_d  = StDone;
      end
      StDone: begin
        if (Out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      result_q <= 32'h0;
      s_q      <= 1'b0;
      e_q      <= 8'h0;
      m_q      <= 24'h0;
      carry_q  <= 1'b0;
      first_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef FPADD_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      first_q  <= first_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef FPADD_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  assign In_ready  = (state_q == StIdle);
  assign Out_valid = (state_q == StDone);
  assign Dp_Load   = (state_q == StLoad);
  assign Dp_Reset  = (state_q == StIdle) || (state_q == StCheck) || (state_q == StClr);
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`ifdef FPADD_TIMEOUT_EN
  assign Timeout   = to_q;
`else
  assign Timeout   = 1'b0;
`endif

  // Hidden bit tracks a nonzero exponent so the reset value of every output is 0;
  // operands reaching the datapath always have a nonzero exponent.
  assign Dp_S_A = a_q[31];
  assign Dp_S_B = b_q[31];
  assign Dp_E_A = a_q[30:23];
  assign Dp_E_B = b_q[30:23];
  assign Dp_M_A = {a_q[30:23] != 8'h00, a_q[22:0]};
  assign Dp_M_B = {b_q[30:23] != 8'h00, b_q[22:0]};

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomized self-checking bench for fp_add_sequencer with a behavioural adder datapath model.
// Exercises the WAIT timeout as well when built with FPADD_TIMEOUT_EN.
module tb_fp_add_sequencer;

  logic        Clk, Reset;
  logic        In_valid, In_ready;
  logic [31:0] A, B;
  logic        Out_valid, Out_ready;
  logic [31:0] Result;
  logic        Overflow, Underflow, Timeout;
  logic        Dp_Reset, Dp_Load;
  logic        Dp_S_A, Dp_S_B;
  logic [7:0]  Dp_E_A, Dp_E_B;
  logic [23:0] Dp_M_A, Dp_M_B;
  logic        Dp_S_Result;
  logic [7:0]  Dp_E_Result;
  logic [23:0] Dp_M_Result;
  logic        Dp_Carry, Dp_Result_stable;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  fp_add_sequencer dut (
    .Clk(Clk), .Reset(Reset),
    .In_valid(In_valid), .In_ready(In_ready), .A(A), .B(B),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Result(Result),
    .Overflow(Overflow), .Underflow(Underflow), .Timeout(Timeout),
    .Dp_Reset(Dp_Reset), .Dp_Load(Dp_Load),
    .Dp_S_A(Dp_S_A), .Dp_S_B(Dp_S_B), .Dp_E_A(Dp_E_A), .Dp_E_B(Dp_E_B),
    .Dp_M_A(Dp_M_A), .Dp_M_B(Dp_M_B),
    .Dp_S_Result(Dp_S_Result), .Dp_E_Result(Dp_E_Result), .Dp_M_Result(Dp_M_Result),
    .Dp_Carry(Dp_Carry), .Dp_Result_stable(Dp_Result_stable)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        c;
  } dp_res_t;

  // Aligned add/subtract of the larger-magnitude operand with the shifted smaller one.
  function automatic dp_res_t dp_compute(input logic sa, input logic [7:0] ea,
                                         input logic [23:0] ma, input logic sb,
                                         input logic [7:0] eb, input logic [23:0] mb);
    dp_res_t     r;
    logic        sl;
    int unsigned el, es, d;
    logic [24:0] ml, msm, sum;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sl = sa; el = ea; es = eb; ml = {1'b0, ma}; msm = {1'b0, mb};
    end else begin
      sl = sb; el = eb; es = ea; ml = {1'b0, mb}; msm = {1'b0, ma};
    end
    d = el - es;
    msm = (d > 24) ? 25'h0 : (msm >> d);
    if (sa == sb) sum = ml + msm;
    else          sum = ml - msm;
    r.s = sl;
    r.e = 8'(el);
    r.m = sum[23:0];
    r.c = (sa == sb) ? sum[24] : 1'b0;
    return r;
  endfunction

  // Full expected outcome: special-value rules, else datapath sum then normalization
  // by leading-zero count with truncation.
  task automatic ref_add(input logic [31:0] a, input logic [31:0] b, output logic [31:0] r,
                         output logic ov, output logic un, output logic byp);
    logic az, bz, ai, bi, an, bn;
    dp_res_t d;
    int e, lz;
    logic [23:0] m;
    az = a[30:23] == 0;  bz = b[30:23] == 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;  bi = b[30:23] == 8'hFF && b[22:0] == 0;
    an = a[30:23] == 8'hFF && a[22:0] != 0;  bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ov = 0; un = 0; byp = 1;
    if (an || bn || (ai && bi && a[31] != b[31])) r = QNaN;
    else if (ai) r = a;
    else if (bi) r = b;
    else if (az && bz) r = {a[31] & b[31], 31'h0};
    else if (az) r = b;
    else if (bz) r = a;
    else begin
      byp = 0;
      d = dp_compute(a[31], a[30:23], {1'b1, a[22:0]}, b[31], b[30:23], {1'b1, b[22:0]});
      e = d.e; m = d.m;
      if (d.c) begin
        e = e + 1;
        m = {1'b1, m[23:1]};
      end
      if (d.c && e >= 255) begin
        ov = 1; r = {d.s, 8'hFF, 23'h0};
      end else if (m == 0) begin
        r = 32'h0;
      end else begin
        lz = 0;
        while (!m[23 - lz]) lz++;
        if (lz == 0) r = {d.s, 8'(e), m[22:0]};
        else if (e > lz) begin
          m = m << lz;
          r = {d.s, 8'(e - lz), m[22:0]};
        end else begin
          un = 1; r = {d.s, 31'h0};
        end
      end
    end
  endtask

  // Datapath model: answers a load after a random number of cycles unless muted.
  bit dp_mute = 0;
  bit dp_pend = 0;
  int dp_wait = 0;
  always @(negedge Clk) begin
    dp_res_t r;
    if (Reset || Dp_Reset) begin
      dp_pend = 0;
      Dp_Result_stable = 1'b0;
    end else if (Dp_Load) begin
      r = dp_compute(Dp_S_A, Dp_E_A, Dp_M_A, Dp_S_B, Dp_E_B, Dp_M_B);
      Dp_S_Result = r.s; Dp_E_Result = r.e; Dp_M_Result = r.m; Dp_Carry = r.c;
      dp_pend = 1;
      dp_wait = $urandom_range(0, 4);
    end else if (dp_pend && !dp_mute) begin
      if (dp_wait == 0) Dp_Result_stable = 1'b1;
      else dp_wait--;
    end
  end

  task automatic wait_out(output int cyc, output int loads, output int falls);
    logic prev_rst;
    cyc = 1; loads = 0; falls = 0; prev_rst = 1'b1;
    while (!Out_valid && cyc < 200) begin
      if (Dp_Load) loads++;
      if (prev_rst && !Dp_Reset) falls++;
      prev_rst = Dp_Reset;
      @(negedge Clk);
      cyc++;
    end
    check_eq("out_valid_seen", Out_valid, 1'b1);
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!In_ready && guard < 50) begin @(negedge Clk); guard++; end
    In_valid = 1'b1; A = a; B = b;
    @(negedge Clk);
    In_valid = 1'b0;
  endtask

  task automatic release_out(input logic [31:0] er, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check_eq("hold", {Out_valid, In_ready, Result}, {1'b1, 1'b0, er});
    end
    Out_ready = 1'b1;
    @(negedge Clk);
    Out_ready = 1'b0;
    check_eq("release", {Out_valid, In_ready, Dp_Reset}, 3'b011);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic eov, eun, byp;
    int cyc, loads, falls;
    ref_add(a, b, er, eov, eun, byp);
    accept(a, b);
    wait_out(cyc, loads, falls);
    check_eq("result", Result, er);
    check_eq("flags", {Overflow, Underflow, Timeout}, {eov, eun, 1'b0});
    if (byp) begin
      check_eq("bypass_latency", cyc, 2);
      check_eq("bypass_no_load", loads, 0);
    end else begin
      check_eq("dp_load_pulses", loads, 1);
      check_eq("dp_reset_pulses", falls, 1);
    end
    release_out(er, hold);
  endtask

  function automatic logic [31:0] rand_fp(input logic [7:0] e_near);
    int k, t;
    logic [22:0] f;
    logic s;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    s = 1'($urandom);
    case (k)
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, f | 23'h1};
      3: return {s, 8'h00, f | 23'h1};
      default: begin
        t = int'(e_near) + $urandom_range(0, 8) - 4;
        if (t < 1) t = 1;
        if (t > 254) t = 254;
        return {s, 8'(t), f};
      end
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int cyc, loads, falls;
    Reset = 1'b1; In_valid = 1'b0; A = 32'h0; B = 32'h0; Out_ready = 1'b0;
    Dp_S_Result = 1'b0; Dp_E_Result = 8'h0; Dp_M_Result = 24'h0;
    Dp_Carry = 1'b0; Dp_Result_stable = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("reset_ctrl", {In_ready, Dp_Reset, Out_valid, Dp_Load, Overflow, Underflow, Timeout},
             7'b1100000);
    check_eq("reset_result", Result, 32'h0);
    check_eq("reset_dp_ops", {Dp_S_A, Dp_S_B, Dp_E_A, Dp_E_B, Dp_M_A[23:0]}, 42'h0);
    check_eq("reset_dp_mb", Dp_M_B, 24'h0);
    Reset = 1'b0;
    @(negedge Clk);

    run_op(32'h3F80_0000, 32'h3F80_0000, 0);
    check_eq("one_plus_one", Result, 32'h4000_0000);
    run_op(32'h4040_0000, 32'hBF80_0000, 1);
    check_eq("three_minus_one", Result, 32'h4000_0000);
    run_op(32'hBF80_0000, 32'h3F80_0000, 0);
    check_eq("cancel_zero", {Result, Underflow}, 33'h0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 0);
    check_eq("inf_minus_inf", Result, QNaN);
    run_op(32'h0000_0000, 32'hC0A0_0000, 0);
    check_eq("zero_plus_x", Result, 32'hC0A0_0000);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 5);
    check_eq("overflow_inf", {Result, Overflow}, {32'h7F80_0000, 1'b1});

    // Reset in the middle of WAIT: operation abandoned, no result follows.
    dp_mute = 1;
    accept(32'h3F80_0000, 32'h4000_0000);
    repeat (5) @(negedge Clk);
    check_eq("mid_wait", {Dp_Reset, In_ready, Out_valid}, 3'b000);
    #2 Reset = 1'b1;
    #1 check_eq("async_reset", {Out_valid, In_ready, Dp_Reset}, 3'b011);
    @(negedge Clk);
    Reset = 1'b0;
    dp_mute = 0;
    repeat (4) @(negedge Clk);
    check_eq("after_reset_idle", {Out_valid, In_ready}, 2'b01);

`ifdef FPADD_TIMEOUT_EN
    dp_mute = 1;
    accept(32'h3F80_0000, 32'h4000_0000);
    wait_out(cyc, loads, falls);
    check_eq("timeout_latency", cyc, 68);
    check_eq("timeout_result", {Result, Timeout}, {QNaN, 1'b1});
    release_out(QNaN, 1);
    dp_mute = 0;
`endif

    for (int n = 0; n < 200; n++) begin
      logic [7:0] en;
      logic [31:0] a, b;
      en = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 9) == 0) en = 8'd254;
      else if ($urandom_range(0, 9) == 0) en = 8'd2;
      a = rand_fp(en);
      b = rand_fp(en);
      if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:0]};
      run_op(a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
